// File: rtl/channel_sink.sv
// Terminal consumer for a valid/ack channel: acks words (optionally with LFSR-driven
// back-pressure) and reports last word, transfer count and XOR checksum.
module channel_sink #(
    parameter int          N            = 16,
    parameter bit          STALL_EN     = 1'b1,
    parameter int          STALL_THRESH = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_d,
    input  logic             in_v,
    output logic             in_a,
    input  logic             enable,
    output logic [N-1:0]     last_d,
    output logic [CNT_W-1:0] xfer_count,
    output logic [N-1:0]     checksum,
    output logic             xfer_pulse,
    input  logic             clear
);

    // Five bits so a threshold of 16 means "always stall".
    localparam logic [4:0] THRESH5 = 5'(STALL_THRESH);

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        stall;
    logic        stall_nxt;
    logic        xfer;

    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_nxt = STALL_EN && ({1'b0, lfsr[3:0]} < THRESH5);

    // reset gates the ack directly so it drops without waiting for a clock edge
    assign in_a = in_v & enable & ~stall & reset;
    assign xfer = in_v & in_a;

    // Free-running: the stall pattern depends only on cycles since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr  <= LFSR_SEED;
            stall <= 1'b1;
        end else begin
            lfsr  <= lfsr_nxt;
            stall <= stall_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d     <= '0;
            xfer_count <= '0;
            checksum   <= '0;
            xfer_pulse <= 1'b0;
        end else begin
            xfer_pulse <= xfer;
            if (clear) begin
                // a word acked on a clear edge is deliberately dropped
                last_d     <= '0;
                xfer_count <= '0;
                checksum   <= '0;
            end else if (xfer) begin
                last_d     <= in_d;
                xfer_count <= xfer_count + 1'b1;
                checksum   <= checksum ^ in_d;
            end
        end
    end

endmodule

// File: tb/tb_channel_sink.sv
// Bench for channel_sink: directed vector table, random streaming against a
// queue-free transfer model, counter wrap and async reset mid-handshake.
module tb_channel_sink;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // dut0: no stalls, N=16
    logic [15:0] d0 = '0; logic v0 = 0, en0 = 1, clr0 = 0, a0, pl0;
    logic [15:0] last0, cks0; logic [31:0] cnt0;
    // dut1: random stalls
    logic [15:0] d1 = '0; logic v1 = 0, a1, pl1;
    logic [15:0] last1, cks1; logic [31:0] cnt1;
    // dut2: 4-bit counter
    logic [15:0] d2 = '0; logic v2 = 0, a2, pl2;
    logic [15:0] last2, cks2; logic [3:0] cnt2;

    channel_sink #(.N(16), .STALL_EN(1'b0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .in_d(d0), .in_v(v0), .in_a(a0), .enable(en0),
        .last_d(last0), .xfer_count(cnt0), .checksum(cks0), .xfer_pulse(pl0), .clear(clr0));

    channel_sink #(.N(16), .STALL_EN(1'b1), .STALL_THRESH(8), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .in_d(d1), .in_v(v1), .in_a(a1), .enable(1'b1),
        .last_d(last1), .xfer_count(cnt1), .checksum(cks1), .xfer_pulse(pl1), .clear(1'b0));

    channel_sink #(.N(16), .STALL_EN(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_d(d2), .in_v(v2), .in_a(a2), .enable(1'b1),
        .last_d(last2), .xfer_count(cnt2), .checksum(cks2), .xfer_pulse(pl2), .clear(1'b0));

    typedef struct {
        logic        v, en, clr;
        logic [15:0] d;
        logic        a;
        logic [31:0] cnt;
        logic [15:0] last, cks;
        logic        pulse;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic v, logic en, logic clr, logic [15:0] d, logic a,
                                logic [31:0] cnt, logic [15:0] last, logic [15:0] cks, logic pulse);
        vec_t r;
        r.v = v; r.en = en; r.clr = clr; r.d = d; r.a = a;
        r.cnt = cnt; r.last = last; r.cks = cks; r.pulse = pulse;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic apply(input vec_t r, input string tag);
        v0 = r.v; en0 = r.en; clr0 = r.clr; d0 = r.d;
        #1;
        chk({tag, ".in_a"}, a0, r.a);
        @(posedge clk); @(negedge clk);
        chk({tag, ".count"}, cnt0, r.cnt);
        chk({tag, ".last"}, last0, r.last);
        chk({tag, ".cks"}, cks0, r.cks);
        chk({tag, ".pulse"}, pl0, r.pulse);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic        tx;
    int          acc, offered, cyc, stalls, k;
    logic [15:0] sent_x, sent_last, x2;

    initial begin
        tbl[0] = mk(1, 1, 0, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0); // stall cycle after reset
        tbl[1] = mk(1, 1, 0, 16'h0001, 1, 1, 16'h0001, 16'h0001, 1);
        tbl[2] = mk(1, 1, 0, 16'h0002, 1, 2, 16'h0002, 16'h0003, 1);
        tbl[3] = mk(1, 1, 0, 16'h0003, 1, 3, 16'h0003, 16'h0000, 1);
        tbl[4] = mk(0, 1, 0, 16'h0004, 0, 3, 16'h0003, 16'h0000, 0);
        tbl[5] = mk(1, 0, 0, 16'h0005, 0, 3, 16'h0003, 16'h0000, 0);
        tbl[6] = mk(1, 1, 1, 16'hBEEF, 1, 0, 16'h0000, 16'h0000, 1);
        tbl[7] = mk(1, 1, 0, 16'h00F0, 1, 1, 16'h00F0, 16'h00F0, 1);
        tbl[8] = mk(1, 1, 0, 16'h0F00, 1, 2, 16'h0F00, 16'h0FF0, 1);
        tbl[9] = mk(0, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);

        // reset state, with valid held high during reset
        v0 = 1; d0 = 16'h0077;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.in_a", a0, 0);
        chk("rst.count", cnt0, 0);
        chk("rst.last", last0, 0);
        chk("rst.cks", cks0, 0);
        chk("rst.pulse", pl0, 0);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply(mk(1, 1, 0, 16'h0055, 1, 1, 16'h0055, 16'h0055, 1), "pre_idle");

        // idle: no ack, state frozen
        for (int i = 0; i < 20; i++) begin
            v0 = 0; d0 = 16'(i);
            #1;
            chk("idle.in_a", a0, 0);
            @(posedge clk); @(negedge clk);
            chk("idle.count", cnt0, 1);
            chk("idle.cks", cks0, 16'h0055);
        end
        chk("idle.last", last0, 16'h0055);

        // async reset mid-handshake
        v0 = 1; d0 = 16'h1234;
        #1;  chk("ar.in_a_pre", a0, 1);
        #2;  reset = 0;
        #1;
        chk("ar.in_a", a0, 0);
        chk("ar.count", cnt0, 0);
        chk("ar.last", last0, 0);
        chk("ar.cks", cks0, 0);
        chk("ar.pulse", pl0, 0);
        @(negedge clk);
        reset = 1;
        #1; chk("ar.stall_after", a0, 0);
        @(posedge clk); @(negedge clk);
        #1; chk("ar.in_a_post", a0, 1);
        @(posedge clk); @(negedge clk);
        v0 = 0;
        chk("ar.count1", cnt0, 1);
        chk("ar.last1", last0, 16'h1234);
        chk("ar.cks1", cks0, 16'h1234);
        chk("ar.pulse1", pl0, 1);
        @(posedge clk); @(negedge clk);
        chk("ar.once", cnt0, 1);
        chk("ar.pulse0", pl0, 0);

        // random stream with back-pressure
        acc = 0; offered = 0; cyc = 0; stalls = 0; sent_x = '0; sent_last = '0;
        while (acc < 1000 && cyc < 20000) begin
            if (!v1 && offered < 1000 && $urandom_range(0, 3) != 0) begin
                d1 = 16'($urandom);
                v1 = 1;
                offered++;
                sent_x ^= d1;
                sent_last = d1;
            end
            #1;
            tx = v1 & a1;
            if (a1 & !v1) chk("rnd.a_without_v", a1, 0);
            if (v1 & !a1) stalls++;
            @(posedge clk); @(negedge clk);
            chk("rnd.pulse", pl1, tx);
            if (tx) begin
                acc++;
                v1 = 0;
                chk("rnd.count", cnt1, acc);
            end
            cyc++;
        end
        chk("rnd.done", acc, 1000);
        chk("rnd.final_count", cnt1, 1000);
        chk("rnd.checksum", cks1, sent_x);
        chk("rnd.last", last1, sent_last);
        chk("rnd.saw_stall", stalls > 0, 1);

        // 4-bit counter wrap
        k = 0; cyc = 0; x2 = '0;
        d2 = 16'($urandom); v2 = 1;
        while (k < 17 && cyc < 100) begin
            #1; tx = a2;
            @(posedge clk); @(negedge clk);
            if (tx) begin
                k++;
                x2 ^= d2;
                if (k == 15) chk("wrap.count15", cnt2, 15);
                if (k == 16) chk("wrap.count16", cnt2, 0);
                d2 = 16'($urandom);
            end
            if (k == 17) v2 = 0;
            cyc++;
        end
        v2 = 0;
        chk("wrap.done", k, 17);
        chk("wrap.count17", cnt2, 1);
        chk("wrap.cks", cks2, x2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
